cello_lut_pipe: RTL and testbench
=================================

// Module: cello_lut_pipe
// PURPOSE
//  Programmable N-input truth-table evaluator; successor to the fixed 3-input NOR-mapped gate netlists.
//  Holds a 2^N_IN-bit truth table (TT). Evaluates N_CH independent input vectors per beat through a
//  2-stage elastic pipeline with valid/ready handshakes. TT is reconfigurable at run time without
//  corrupting in-flight samples. Sits between stimulus sequencer and readout/scoreboard logic.
// PARAMETERS
//  N_IN     3      inputs per channel; TT width TT_W = 2**N_IN
//  N_CH     4      parallel channels sharing one TT
//  TT_INIT  'h69   TT value after reset (bit i = output for input vector value i)
//  CNT_W    16     width of saturating evaluation counter
// PORTS
//  clk        in   1          clock; all state on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  cfg_req    in   1          request TT update (single-cycle pulse)
//  cfg_tt     in   TT_W       new TT, parallel load (unused when serial load compiled in)
//  cfg_sbit   in   1          serial TT bit (serial load only)
//  cfg_svalid in   1          cfg_sbit qualifier (serial load only)
//  cfg_busy   out  1          1 while draining or loading
//  in_valid   in   1          input beat valid
//  in_ready   out  1          block accepts beat when in_valid && in_ready
//  in_data    in   N_CH*N_IN  channel c uses in_data[c*N_IN +: N_IN]
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts when out_valid && out_ready
//  out_data   out  N_CH       out_data[c] = TT[channel c vector]
//  eval_cnt   out  CNT_W      count of completed output handshakes, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RUN, TT=TT_INIT, both stage valids 0, out_valid=0, out_data=0,
//   eval_cnt=0, cfg_busy=0. Reset mid-load or mid-drain aborts; partial serial TT discarded.
//  Pipeline: S1 registers in_data; S2 registers TT lookup of S1. Latency 2 cycles accept->out_valid.
//   Stage advances when empty or its consumer takes it that cycle; 1 beat/cycle under out_ready=1.
//   in_ready = (state==RUN) && !cfg_req && (!s1_v || s1 advancing). out_data stable while out_valid && !out_ready.
//  FSM states RUN, DRAIN, LOAD:
//   RUN  : cfg_req -> DRAIN (beat offered same cycle is NOT accepted).
//   DRAIN: in_ready=0; waits until s1_v==0 && s2_v==0 (backpressure may hold it indefinitely) -> LOAD.
//   LOAD : parallel: TT<=cfg_tt captured at cfg_req cycle (held in shadow reg), 1 cycle -> RUN.
//   cfg_busy = (state != RUN). cfg_req outside RUN ignored.
//  In-flight samples always use the TT active when accepted; first beat after LOAD uses new TT.
//  eval_cnt: +1 per output handshake; holds at 2**CNT_W-1.
// CONFIGURATION
//  CELLO_LUT_SERIAL_LOAD_EN defined: cfg_tt ignored; LOAD shifts cfg_sbit on each cfg_svalid cycle,
//   LSB (TT[0]) first, into shadow reg; after TT_W bits TT<=shadow, -> RUN. cfg_svalid outside LOAD ignored.
//  Undefined: parallel load as above; cfg_sbit/cfg_svalid present but unused.
// STRUCTURE
//  cello_lut_pkg: state enum {RUN,DRAIN,LOAD}, tt_w(N_IN) function, TT_INIT default constant.
//  Sub-module cello_lut_stage: elastic one-entry register slice (valid/ready/data), instantiated for S1, S2.
//  Top holds FSM, TT + shadow reg, serial bit counter, lookup mux, eval_cnt.
// TESTING
//  1 Reset defaults, N_CH=4: in_data={3'b111,3'b011,3'b001,3'b000}, out_ready=1 -> 2 cycles later out_data=4'b0101.
//  2 Streaming 8 beats back-to-back, out_ready=1 -> 8 results on consecutive cycles, eval_cnt=8.
//  3 Backpressure: out_ready=0 for 5 cycles with 3 beats offered -> only 2 accepted, out_data stable, none lost.
//  4 cfg_req with cfg_tt=8'h96 while 2 beats in flight -> those return old (0x69) results, cfg_busy high
//    until drained+1 cycle, next beat 3'b000 -> 0.
//  5 Serial load (macro on): 8 bits of 0xFE LSB first with gaps in cfg_svalid -> input 3'b000 -> 0, 3'b101 -> 1.
//  6 rst_n low mid-DRAIN and CNT_W=4 saturate: reset -> TT=0x69, cfg_busy=0; 20 handshakes -> eval_cnt=15.

Source files
------------

// File: rtl/cello_lut_pkg.sv
// -----------------------------------------------------------------------------
// cello_lut_pkg
// Shared types and constants for the cello_lut_pipe truth-table evaluator.
//   lut_state_e     : configuration FSM states (RUN, DRAIN, LOAD)
//   TT_INIT_DEFAULT : truth table loaded at reset for the default N_IN=3 build
//   tt_w()          : truth-table width for a given number of inputs (2**n_in)
// -----------------------------------------------------------------------------
package cello_lut_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } lut_state_e;

    localparam logic [7:0] TT_INIT_DEFAULT = 8'h69;

    function automatic int unsigned tt_w(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/cello_lut_stage.sv
// -----------------------------------------------------------------------------
// cello_lut_stage
// One-entry elastic register slice with valid/ready handshakes. Accepts a new
// entry when empty or when the held entry leaves in the same cycle, giving full
// throughput with a single register. Held data is frozen while out_valid is
// high and out_ready is low.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_data payload (W bits)
//   out_valid/out_ready   : downstream handshake, out_data payload (W bits)
// -----------------------------------------------------------------------------
module cello_lut_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice register: refill or empty whenever the current entry may move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/cello_lut_pipe.sv
// -----------------------------------------------------------------------------
// cello_lut_pipe
// Programmable N_IN-input truth-table evaluator for N_CH channels per beat.
// Two-stage elastic pipeline: S1 registers the input vectors, S2 registers the
// truth-table lookup of S1. The table can be replaced at run time: a cfg_req
// stops intake, waits for the pipeline to empty, then loads the new table, so
// every in-flight sample is evaluated with the table that was active when it
// was accepted.
//
// Build option: CELLO_LUT_SERIAL_LOAD_EN
//   defined   : new table shifted in on cfg_sbit/cfg_svalid during LOAD, LSB
//               first; cfg_tt is ignored.
//   undefined : new table taken in parallel from cfg_tt at the cfg_req cycle;
//               cfg_sbit/cfg_svalid are ignored.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   cfg_req                : single-cycle table-update request (honoured in RUN)
//   cfg_tt                 : new table, parallel load
//   cfg_sbit, cfg_svalid   : serial table bit and its qualifier
//   cfg_busy               : high while draining or loading
//   in_valid/in_ready      : input handshake, in_data = N_CH vectors of N_IN bits
//   out_valid/out_ready    : output handshake, out_data[c] = TT[vector c]
//   eval_cnt               : saturating count of output handshakes
// -----------------------------------------------------------------------------
module cello_lut_pipe
    import cello_lut_pkg::*;
#(
    parameter int unsigned               N_IN    = 3,
    parameter int unsigned               N_CH    = 4,
    parameter logic [tt_w(N_IN)-1:0]     TT_INIT = TT_INIT_DEFAULT,
    parameter int unsigned               CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_req,
    input  logic [tt_w(N_IN)-1:0]  cfg_tt,
    input  logic                   cfg_sbit,
    input  logic                   cfg_svalid,
    output logic                   cfg_busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*N_IN-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CH-1:0]        out_data,
    output logic [CNT_W-1:0]       eval_cnt
);

    localparam int unsigned      TT_W       = tt_w(N_IN);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    lut_state_e             state_r;
    lut_state_e             state_nxt_s;
    logic [TT_W-1:0]        tt_r;
    logic [TT_W-1:0]        tt_nxt_s;
    logic [TT_W-1:0]        shadow_r;
    logic [TT_W-1:0]        shadow_nxt_s;
    logic [CNT_W-1:0]       eval_cnt_r;

    logic                   accept_en_s;
    logic                   s1_in_valid_s;
    logic                   s1_in_ready_s;
    logic                   s1_valid_s;
    logic                   s1_ready_s;
    logic [N_CH*N_IN-1:0]   s1_data_s;
    logic [N_CH-1:0]        lookup_s;

`ifdef CELLO_LUT_SERIAL_LOAD_EN
    localparam logic [N_IN-1:0] BIT_LAST_C = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] BIT_ONE_C  = {{(N_IN-1){1'b0}}, 1'b1};

    logic [N_IN-1:0]        bit_cnt_r;
    logic [N_IN-1:0]        bit_cnt_nxt_s;
    logic                   unused_cfg_s;

    assign unused_cfg_s = ^cfg_tt;
`else
    logic                   unused_cfg_s;

    assign unused_cfg_s = cfg_sbit ^ cfg_svalid;
`endif

    // Intake is closed outside RUN and in the cfg_req cycle itself, so a beat
    // offered alongside the request waits until the new table is in place.
    assign accept_en_s   = (state_r == RUN) && !cfg_req;
    assign s1_in_valid_s = in_valid && accept_en_s;
    assign in_ready      = accept_en_s && s1_in_ready_s;
    assign cfg_busy      = (state_r != RUN);
    assign eval_cnt      = eval_cnt_r;

    cello_lut_stage #(
        .W (N_CH*N_IN)
    ) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_in_valid_s),
        .in_ready  (s1_in_ready_s),
        .in_data   (in_data),
        .out_valid (s1_valid_s),
        .out_ready (s1_ready_s),
        .out_data  (s1_data_s)
    );

    // Each channel indexes the shared table with its own input vector.
    for (genvar c = 0; c < N_CH; c++) begin : g_lookup
        assign lookup_s[c] = tt_r[s1_data_s[c*N_IN +: N_IN]];
    end

    cello_lut_stage #(
        .W (N_CH)
    ) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid_s),
        .in_ready  (s1_ready_s),
        .in_data   (lookup_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Configuration FSM next-state, table, shadow and serial-counter updates.
    always_comb begin
        state_nxt_s  = state_r;
        tt_nxt_s     = tt_r;
        shadow_nxt_s = shadow_r;
`ifdef CELLO_LUT_SERIAL_LOAD_EN
        bit_cnt_nxt_s = bit_cnt_r;
`endif
        case (state_r)
            RUN: begin
                if (cfg_req) begin
                    state_nxt_s = DRAIN;
`ifdef CELLO_LUT_SERIAL_LOAD_EN
                    bit_cnt_nxt_s = {N_IN{1'b0}};
`else
                    shadow_nxt_s = cfg_tt;
`endif
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                // Both stages must be empty; downstream backpressure may hold us here.
                if (!s1_valid_s && !out_valid) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            LOAD: begin
`ifdef CELLO_LUT_SERIAL_LOAD_EN
                if (cfg_svalid) begin
                    // Shift right so the first bit received ends up in TT[0].
                    shadow_nxt_s = {cfg_sbit, shadow_r[TT_W-1:1]};
                    if (bit_cnt_r == BIT_LAST_C) begin
                        tt_nxt_s      = shadow_nxt_s;
                        bit_cnt_nxt_s = {N_IN{1'b0}};
                        state_nxt_s   = RUN;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_ONE_C;
                        state_nxt_s   = LOAD;
                    end
                end else begin
                    state_nxt_s = LOAD;
                end
`else
                tt_nxt_s    = shadow_r;
                state_nxt_s = RUN;
`endif
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Configuration state, active table and shadow table registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            tt_r     <= TT_INIT;
            shadow_r <= {TT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            tt_r     <= tt_nxt_s;
            shadow_r <= shadow_nxt_s;
        end
    end

`ifdef CELLO_LUT_SERIAL_LOAD_EN
    // Count of serial table bits received in the current LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= {N_IN{1'b0}};
        end else begin
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end
`endif

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready && (eval_cnt_r != CNT_MAX_C)) begin
            eval_cnt_r <= eval_cnt_r + CNT_ONE_C;
        end
    end

endmodule

// File: tb/tb_cello_lut_pipe.sv
// -----------------------------------------------------------------------------
// tb_cello_lut_pipe
// Directed self-checking bench for cello_lut_pipe (N_IN=3, N_CH=4, CNT_W=4).
// Inputs are driven 1 ns after the rising edge; outputs are sampled 2 ns after
// the rising edge, before the next edge, so a sample with out_valid and
// out_ready both high marks the handshake taken at the following edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cello_lut_pipe;

    logic        clk;
    logic        rst_n;
    logic        cfg_req;
    logic [7:0]  cfg_tt;
    logic        cfg_sbit;
    logic        cfg_svalid;
    logic        cfg_busy;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [3:0]  eval_cnt;

    int n_checks = 0;
    int n_errors = 0;

    cello_lut_pipe #(
        .N_IN    (3),
        .N_CH    (4),
        .TT_INIT (8'h69),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_req    (cfg_req),
        .cfg_tt     (cfg_tt),
        .cfg_sbit   (cfg_sbit),
        .cfg_svalid (cfg_svalid),
        .cfg_busy   (cfg_busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .eval_cnt   (eval_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference truth-table evaluation of four 3-bit channel vectors.
    function automatic logic [3:0] model(input logic [7:0] tt, input logic [11:0] d);
        logic [3:0] r;
        logic [2:0] v;
        r = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            v    = d[c*3 +: 3];
            r[c] = tt[v];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        cfg_req    = 1'b0;
        cfg_tt     = 8'h00;
        cfg_sbit   = 1'b0;
        cfg_svalid = 1'b0;
        in_valid   = 1'b0;
        in_data    = 12'h000;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 4'b0000) begin n_errors++; $display("FAIL reset_out_data: got %b want 0000", out_data); end
        n_checks++; if (eval_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_eval_cnt: got %0d want 0", eval_cnt); end
        n_checks++; if (cfg_busy !== 1'b0) begin n_errors++; $display("FAIL reset_cfg_busy: got %b want 0", cfg_busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_first_lookup();
        in_valid  = 1'b1;
        in_data   = {3'b111, 3'b011, 3'b001, 3'b000};
        out_ready = 1'b1;
        settle();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL first_in_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        settle();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL first_latency: out_valid got %b want 0 one cycle after accept", out_valid); end
        step();
        settle();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 4'b0101) begin n_errors++; $display("FAIL first_out_data: got %b want 0101", out_data); end
        step();
        settle();
        n_checks++; if (eval_cnt !== 4'd1) begin n_errors++; $display("FAIL first_eval_cnt: got %0d want 1", eval_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL first_out_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [11:0] beats [8];
        logic [3:0]  expv  [8];
        int sent, rcv, first, cyc, gaps, stalls;
        logic acc;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beats[i] = {3'(i + 3), 3'(i + 2), 3'(i + 1), 3'(i)};
            expv[i]  = model(8'h69, beats[i]);
        end
        sent = 0; rcv = 0; first = -1; cyc = 0; gaps = 0; stalls = 0;
        while (rcv < 8 && cyc < 40) begin
            in_valid = (sent < 8);
            in_data  = (sent < 8) ? beats[sent] : 12'h000;
            settle();
            if (out_valid) begin
                n_checks++; if (out_data !== expv[rcv]) begin n_errors++; $display("FAIL stream_data[%0d]: got %b want %b", rcv, out_data, expv[rcv]); end
                if (first < 0) first = cyc;
                rcv++;
            end else if (first >= 0) begin
                gaps++;
            end
            if (in_valid && !in_ready) stalls++;
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        settle();
        n_checks++; if (rcv !== 8) begin n_errors++; $display("FAIL stream_count: got %0d want 8", rcv); end
        n_checks++; if (first !== 2) begin n_errors++; $display("FAIL stream_latency: first result cycle %0d want 2", first); end
        n_checks++; if (gaps !== 0) begin n_errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
        n_checks++; if (stalls !== 0) begin n_errors++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
        n_checks++; if (eval_cnt !== 4'd8) begin n_errors++; $display("FAIL stream_eval_cnt: got %0d want 8", eval_cnt); end
    endtask

    task automatic test_backpressure();
        logic [11:0] bp   [3];
        logic [3:0]  expv [3];
        int idx, rcv, cyc;
        logic acc;
        do_reset();
        bp[0] = {3'b000, 3'b001, 3'b010, 3'b011};
        bp[1] = {3'b100, 3'b101, 3'b110, 3'b111};
        bp[2] = {3'b110, 3'b000, 3'b011, 3'b101};
        for (int i = 0; i < 3; i++) expv[i] = model(8'h69, bp[i]);
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = bp[idx];
            settle();
            if (k >= 2) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== expv[0]) begin n_errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%b want v=1 d=%b", k, out_valid, out_data, expv[0]); end
            end
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        n_checks++; if (idx !== 2) begin n_errors++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        out_ready = 1'b1;
        rcv = 0; cyc = 0;
        while (rcv < 3 && cyc < 30) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? bp[idx] : 12'h000;
            settle();
            if (out_valid) begin
                n_checks++; if (out_data !== expv[rcv]) begin n_errors++; $display("FAIL bp_data[%0d]: got %b want %b", rcv, out_data, expv[rcv]); end
                rcv++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        settle();
        n_checks++; if (rcv !== 3) begin n_errors++; $display("FAIL bp_count: got %0d want 3", rcv); end
        n_checks++; if (eval_cnt !== 4'd3) begin n_errors++; $display("FAIL bp_eval_cnt: got %0d want 3", eval_cnt); end
    endtask

`ifndef CELLO_LUT_SERIAL_LOAD_EN
    task automatic test_reconfig();
        logic [11:0] p, q, r;
        p = {3'b001, 3'b010, 3'b011, 3'b100};
        q = {3'b111, 3'b000, 3'b101, 3'b110};
        r = {3'b111, 3'b110, 3'b101, 3'b000};
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = p;
        settle();
        step();
        in_data = q;
        settle();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL cfg_second_beat_ready: got %b want 1", in_ready); end
        step();
        cfg_req = 1'b1;
        cfg_tt  = 8'h96;
        in_data = r;
        settle();
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL cfg_req_blocks_beat: in_ready got %b want 0", in_ready); end
        step();
        cfg_req = 1'b0;
        cfg_tt  = 8'h00;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_checks++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin n_errors++; $display("FAIL cfg_drain_hold[%0d]: busy=%b ready=%b want 1 0", k, cfg_busy, in_ready); end
            step();
        end
        out_ready = 1'b1;
        settle();
        n_checks++; if (out_valid !== 1'b1 || out_data !== model(8'h69, p)) begin n_errors++; $display("FAIL cfg_old_p: got v=%b d=%b want v=1 d=%b", out_valid, out_data, model(8'h69, p)); end
        step();
        settle();
        n_checks++; if (out_valid !== 1'b1 || out_data !== model(8'h69, q)) begin n_errors++; $display("FAIL cfg_old_q: got v=%b d=%b want v=1 d=%b", out_valid, out_data, model(8'h69, q)); end
        step();
        settle();
        n_checks++; if (out_valid !== 1'b0 || cfg_busy !== 1'b1 || in_ready !== 1'b0) begin n_errors++; $display("FAIL cfg_drained: v=%b busy=%b ready=%b want 0 1 0", out_valid, cfg_busy, in_ready); end
        step();
        settle();
        n_checks++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin n_errors++; $display("FAIL cfg_load_cycle: busy=%b ready=%b want 1 0", cfg_busy, in_ready); end
        step();
        settle();
        n_checks++; if (cfg_busy !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL cfg_back_to_run: busy=%b ready=%b want 0 1", cfg_busy, in_ready); end
        step();
        in_valid = 1'b0;
        settle();
        step();
        settle();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'b1000) begin n_errors++; $display("FAIL cfg_new_tt: got v=%b d=%b want v=1 d=1000", out_valid, out_data); end
        step();
    endtask
`endif

`ifdef CELLO_LUT_SERIAL_LOAD_EN
    task automatic test_serial();
        logic [7:0] bits;
        int b, cyc;
        logic took;
        bits = 8'hFE;
        do_reset();
        out_ready = 1'b1;
        cfg_req   = 1'b1;
        cfg_tt    = 8'h00;
        settle();
        step();
        cfg_req    = 1'b0;
        cfg_svalid = 1'b1;
        cfg_sbit   = 1'b1;
        settle();
        n_checks++; if (cfg_busy !== 1'b1) begin n_errors++; $display("FAIL ser_drain_busy: got %b want 1", cfg_busy); end
        step();
        b = 0; cyc = 0;
        while (b < 8 && cyc < 40) begin
            cfg_svalid = (cyc % 3 != 1);
            cfg_sbit   = cfg_svalid ? bits[b] : ~bits[b];
            settle();
            n_checks++; if (cfg_busy !== 1'b1) begin n_errors++; $display("FAIL ser_load_busy[%0d]: got %b want 1", cyc, cfg_busy); end
            took = cfg_svalid;
            step();
            if (took) b++;
            cyc++;
        end
        cfg_svalid = 1'b0;
        cfg_sbit   = 1'b0;
        settle();
        n_checks++; if (cfg_busy !== 1'b0) begin n_errors++; $display("FAIL ser_done_busy: got %b want 0", cfg_busy); end
        in_valid = 1'b1;
        in_data  = {3'b111, 3'b110, 3'b101, 3'b000};
        settle();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL ser_in_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        settle();
        step();
        settle();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'b1110) begin n_errors++; $display("FAIL ser_new_tt: got v=%b d=%b want v=1 d=1110", out_valid, out_data); end
        step();
    endtask
`endif

    task automatic test_reset_saturate();
        int sent, rcv, cyc;
        logic acc;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {3'b010, 3'b100, 3'b110, 3'b001};
        settle();
        step();
        in_valid = 1'b0;
        settle();
        step();
        cfg_req = 1'b1;
        cfg_tt  = 8'h00;
        settle();
        step();
        cfg_req = 1'b0;
        settle();
        n_checks++; if (cfg_busy !== 1'b1) begin n_errors++; $display("FAIL rst_pre_busy: got %b want 1", cfg_busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (cfg_busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy: got %b want 0", cfg_busy); end
        n_checks++; if (out_valid !== 1'b0 || out_data !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_out: v=%b d=%b want 0 0000", out_valid, out_data); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 20 && cyc < 80) begin
            in_valid = (sent < 20);
            in_data  = {3'b111, 3'b011, 3'b001, 3'b000};
            settle();
            if (out_valid) begin
                n_checks++; if (out_data !== 4'b0101) begin n_errors++; $display("FAIL rst_tt_restored[%0d]: got %b want 0101", rcv, out_data); end
                rcv++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        settle();
        n_checks++; if (rcv !== 20) begin n_errors++; $display("FAIL sat_count: got %0d want 20", rcv); end
        n_checks++; if (eval_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_eval_cnt: got %0d want 15", eval_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_lookup();
        test_stream();
        test_backpressure();
`ifdef CELLO_LUT_SERIAL_LOAD_EN
        test_serial();
`else
        test_reconfig();
`endif
        test_reset_saturate();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
